// File: rtl/freq_to_phase.sv
// Converts a target pitch (Q16.16 Hz) to an FFT bin position and per-hop phase advance,
// using a 32-cycle shift-add multiplier, and maintains a running synthesis phase accumulator.
module freq_to_phase #(
  parameter logic [31:0] HZ_TO_BIN     = 32'h02BB0CF9,
  parameter int unsigned LOG2_OVERSAMP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] frequency,
  input  logic        phase_clear,
  output logic        busy,
  output logic        done,
  output logic [8:0]  bin_index,
  output logic [31:0] bin_frac,
  output logic [31:0] phase_inc,
  output logic [31:0] phase_acc,
  output logic        overflow
);

  localparam int unsigned PHASE_SHIFT = 9 - LOG2_OVERSAMP;

  typedef enum logic [1:0] {IDLE, MUL, FINISH} state_t;

  state_t      state;
  logic [31:0] mplier;
  logic [63:0] mcand;
  logic [63:0] product;
  logic [4:0]  count;

  logic [31:0] frac_w;
  logic [8:0]  idx_w;
  logic        ovf_w;
  logic [31:0] inc_w;
  logic [9:0]  round_sum;
  logic        unused_bits;

  assign unused_bits = ^product[24:0];

  // Rounding carry into bin 512 is folded into the same saturation as a high-bit overflow.
  always_comb begin
    frac_w    = product[56:25];
    round_sum = {1'b0, product[56:48]} + {9'd0, product[47]};
    idx_w     = round_sum[8:0];
    ovf_w     = 1'b0;
    if (|product[63:57]) begin
      frac_w = '1;
      idx_w  = 9'd511;
      ovf_w  = 1'b1;
    end else if (round_sum[9]) begin
      idx_w = 9'd511;
      ovf_w = 1'b1;
    end
    inc_w = frac_w << PHASE_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mplier    <= '0;
      mcand     <= '0;
      product   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bin_index <= '0;
      bin_frac  <= '0;
      phase_inc <= '0;
      phase_acc <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (phase_clear) phase_acc <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            mplier  <= frequency;
            mcand   <= {32'd0, HZ_TO_BIN};
            product <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) state <= FINISH;
        end
        FINISH: begin
          bin_frac  <= frac_w;
          bin_index <= idx_w;
          overflow  <= ovf_w;
          phase_inc <= inc_w;
          // A clear coinciding with the result edge restarts the accumulator at the new increment.
          phase_acc <= (phase_clear ? 32'd0 : phase_acc) + inc_w;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_to_phase.sv
// Self-checking bench for freq_to_phase: directed pitches plus random frequencies
// compared against an arithmetic model of the Hz-to-bin conversion.
module tb_freq_to_phase;

  localparam logic [31:0] HZ = 32'h02BB0CF9;
  localparam int unsigned L  = 2;

  logic        clk = 1'b0;
  logic        reset, start, phase_clear;
  logic [31:0] frequency;
  logic        busy, done, overflow;
  logic [8:0]  bin_index;
  logic [31:0] bin_frac, phase_inc, phase_acc;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_acc = '0;

  freq_to_phase #(.HZ_TO_BIN(HZ), .LOG2_OVERSAMP(L)) dut (
    .clk(clk), .reset(reset), .start(start), .frequency(frequency),
    .phase_clear(phase_clear), .busy(busy), .done(done), .bin_index(bin_index),
    .bin_frac(bin_frac), .phase_inc(phase_inc), .phase_acc(phase_acc), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] f, output logic [31:0] frac,
                                output logic [8:0] idx, output logic ovf, output logic [31:0] inc);
    longint unsigned fu, p, fr, r;
    fu = 64'(f);
    p  = fu * 64'(HZ);
    if (p >= (64'd1 << 57)) begin
      frac = '1;
      idx  = 9'd511;
      ovf  = 1'b1;
    end else begin
      frac = 32'(p / (64'd1 << 25));
      fr   = 64'(frac);
      r    = (fr + 64'd4194304) / 64'd8388608;
      ovf  = (r >= 64'd512);
      idx  = ovf ? 9'd511 : 9'(r);
    end
    fr  = 64'(frac);
    inc = 32'(fr * (64'd1 << (9 - L)));
  endfunction

  // One complete conversion with its own result comparisons; optionally fires a stray
  // start mid-multiply or asserts phase_clear on the result edge.
  task automatic convert(input logic [31:0] f, input bit clr_fin, input bit mid_start, input string tag);
    logic [31:0] frac, inc;
    logic [8:0]  idx;
    logic        ovf;
    int          n;
    model(f, frac, idx, ovf, inc);
    m_acc = clr_fin ? inc : m_acc + inc;
    @(negedge clk); frequency = f; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", tag, busy); end
    n = 0;
    while (n < 60) begin
      if (mid_start && n == 5) begin start = 1'b1; frequency = ~f; end
      if (mid_start && n == 9) start = 1'b0;
      if (clr_fin && n == 32) phase_clear = 1'b1;
      @(posedge clk); #1; n++;
      phase_clear = 1'b0;
      if (done === 1'b1) break;
    end
    checks++; if (n != 33) begin errors++; $display("FAIL %s latency got %0d want 33", tag, n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", tag, busy); end
    checks++; if (bin_frac !== frac) begin errors++; $display("FAIL %s bin_frac got %h want %h", tag, bin_frac, frac); end
    checks++; if (bin_index !== idx) begin errors++; $display("FAIL %s bin_index got %0d want %0d", tag, bin_index, idx); end
    checks++; if (overflow !== ovf) begin errors++; $display("FAIL %s overflow got %b want %b", tag, overflow, ovf); end
    checks++; if (phase_inc !== inc) begin errors++; $display("FAIL %s phase_inc got %h want %h", tag, phase_inc, inc); end
    checks++; if (phase_acc !== m_acc) begin errors++; $display("FAIL %s phase_acc got %h want %h", tag, phase_acc, m_acc); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", tag, done); end
  endtask

  task automatic test_reset();
    int seen;
    seen = 0;
    reset = 1'b1; start = 1'b0; phase_clear = 1'b0; frequency = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_idle busy_or_done_cycles got %0d want 0", seen); end
    checks++;
    if ({bin_index, bin_frac, phase_inc, phase_acc, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_values got idx=%0d frac=%h inc=%h acc=%h ovf=%b want all 0",
               bin_index, bin_frac, phase_inc, phase_acc, overflow);
    end
    m_acc = '0;
  endtask

  task automatic test_one_bin();
    for (int k = 0; k < 4; k++) begin
      convert(32'h005DC000, 1'b0, 1'b0, "one_bin");
      checks++; if (bin_index !== 9'd1) begin errors++; $display("FAIL one_bin_index got %0d want 1", bin_index); end
    end
    checks++;
    if (phase_acc > 32'd1024 && phase_acc < 32'hFFFFFC00) begin
      errors++; $display("FAIL one_bin_wrap phase_acc got %h want near 0", phase_acc);
    end
  endtask

  task automatic test_440();
    convert(32'h01B80000, 1'b0, 1'b0, "a440");
    checks++; if (bin_index !== 9'd5) begin errors++; $display("FAIL a440_index got %0d want 5", bin_index); end
  endtask

  task automatic test_overflow();
    convert(32'hBB800000, 1'b0, 1'b0, "nyquist2x");
    checks++;
    if (overflow !== 1'b1 || bin_index !== 9'd511 || bin_frac !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL overflow_sat got ovf=%b idx=%0d frac=%h want 1 511 ffffffff", overflow, bin_index, bin_frac);
    end
    convert(32'd47990 << 16, 1'b0, 1'b0, "round_carry");
    convert(32'd47940 << 16, 1'b0, 1'b0, "below_carry");
  endtask

  task automatic test_random();
    logic [31:0] f;
    for (int i = 0; i < 10; i++) begin
      f = $urandom;
      if (i % 3 != 0) f = f % 32'h5DC00000;
      convert(f, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    extra = 0;
    convert(32'h0C350000, 1'b0, 1'b1, "start_ignored");
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL start_ignored extra_done got %0d want 0", extra); end
  endtask

  task automatic test_phase_clear();
    logic [31:0] held;
    convert(32'h01B80000, 1'b0, 1'b0, "pre_clear");
    convert(32'h03E80000, 1'b1, 1'b0, "clear_on_finish");
    held = phase_inc;
    @(negedge clk); phase_clear = 1'b1;
    @(posedge clk); #1; phase_clear = 1'b0;
    m_acc = '0;
    checks++; if (phase_acc !== m_acc) begin errors++; $display("FAIL idle_clear phase_acc got %h want 0", phase_acc); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (phase_inc !== held) begin errors++; $display("FAIL hold phase_inc got %h want %h", phase_inc, held); end
  endtask

  task automatic test_reset_mid();
    int extra;
    extra = 0;
    @(negedge clk); frequency = 32'h01B80000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    m_acc = '0;
    checks++;
    if ({busy, done, bin_index, bin_frac, phase_inc, phase_acc, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b idx=%0d frac=%h inc=%h acc=%h ovf=%b want all 0",
               busy, done, bin_index, bin_frac, phase_inc, phase_acc, overflow);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL reset_mid late_done got %0d want 0", extra); end
    convert(32'h005DC000, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    convert(32'h00BB8000, 1'b0, 1'b0, "b2b_first");
    convert(32'h2EE00000, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_one_bin();
    test_440();
    test_overflow();
    test_random();
    test_start_ignored();
    test_phase_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
